red_arbiter: RTL and testbench
==============================

// Module: red_arbiter
// PURPOSE
//  Shares one RED reduction datapath (red_16bit) between two requesters, e.g. the ALU issue path and a test/DMA port.
//  Round-robin grant, operands latched, one registered result presented on a shared response channel with backpressure.
//  Single reduction in flight; the result is held until it is consumed.
// PARAMETERS
//  RR_RESET_PRI  0  requester that wins the first two-way contention after reset (0 or 1)
// PORTS
//  clk        in   1   system clock, all logic on rising edge
//  rst_n      in   1   synchronous active-low reset
//  req0_vld   in   1   requester 0 has operands
//  req0_A     in   16  requester 0 operand A = {a,b}
//  req0_B     in   16  requester 0 operand B = {c,d}
//  req0_rdy   out  1   requester 0 accepted when req0_vld & req0_rdy
//  req1_vld   in   1   requester 1 has operands
//  req1_A     in   16  requester 1 operand A
//  req1_B     in   16  requester 1 operand B
//  req1_rdy   out  1   requester 1 accepted when req1_vld & req1_rdy
//  rsp_vld    out  1   result valid
//  rsp_id     out  1   requester that owns rsp_sum
//  rsp_sum    out  16  sign-extended (a+b)+(c+d)
//  rsp_rdy    in   1   consumer takes result when rsp_vld & rsp_rdy
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): state=IDLE, rsp_vld=0, rsp_id=0, rsp_sum=0, last_grant=~RR_RESET_PRI. Counters clear.
//  - FSM states IDLE, EXEC, HOLD.
//     IDLE: reqN_rdy driven combinationally from the grant decision. Any valid request gives one grant, latches its A/B/id, -> EXEC.
//     EXEC: both rdy=0. The red_16bit output is registered into rsp_sum/rsp_id, rsp_vld<=1, -> HOLD.
//     HOLD: both rdy=0. rsp_vld, rsp_id and rsp_sum stay stable. rsp_rdy=1 -> rsp_vld<=0, -> IDLE.
//  - Grant rules:
//     Only one vld -> grant it.
//     Both vld -> grant ~last_grant.
//     last_grant updates only on an accepted handshake.
//     Never assert both rdy in one cycle.
//  - Latency: accepted in cycle t, rsp_vld=1 from cycle t+2. Minimum 3 cycles per transaction, so peak throughput is 1/3.
//  - Arithmetic:
//     a,b,c,d are signed 8-bit.
//     Each pair sum is 9-bit signed; the final sum is 10-bit signed, sign-extended to 16.
//     No saturation or wrap at 16 bits; the result is exact.
//  - A requester may drop vld before grant with no effect. Operands are sampled only at the handshake.
//  - rsp_rdy held high in HOLD: exits after exactly 1 HOLD cycle.
//  - rsp_rdy outside HOLD is ignored.
//  - Reset mid-EXEC/HOLD: the transaction is discarded, no rsp_vld pulse, outputs return to reset values.
// CONFIGURATION
//  RED_ARB_STATS_EN
//   Defined: adds outputs gnt0_cnt[15:0] and gnt1_cnt[15:0].
//    Each increments on its own accepted handshake and saturates at 16'hFFFF.
//    Both clear on reset.
//   Undefined: these ports and counters do not exist. All other behaviour is identical.
// STRUCTURE
//  - Shared package red_pkg:
//     state encoding localparams ST_IDLE=2'd0, ST_EXEC=2'd1, ST_HOLD=2'd2
//     RED_W=16
//     requester id width = 1
//  - One sub-module: red_16bit, instantiated once and fed from the latched operand registers.
//  - All else (FSM, grant, registers, counters) lives in red_arbiter.
// TESTING
//  1. Basic: req0 A=16'h7F7F, B=16'h0101 -> rsp_vld 2 cycles after accept, rsp_id=0, rsp_sum=16'h0100.
//  2. Negative: req1 A=16'h8080, B=16'hFFFF -> rsp_id=1, rsp_sum=16'hFEFE (-258).
//  3. Contention: both vld continuously, rsp_rdy=1 -> grants 0,1,0,1 (RR_RESET_PRI=0), 1 result every 3 cycles.
//  4. Backpressure: rsp_rdy=0 for 5 cycles in HOLD -> rsp_sum/rsp_id stable, both rdy=0, no new accept until rsp_rdy=1.
//  5. Reset mid-EXEC: accept, then rst_n=0 next cycle -> no rsp_vld, state IDLE, last_grant back to ~RR_RESET_PRI.
//  6. STATS_EN: 3 req0 and 2 req1 transactions -> gnt0_cnt=3, gnt1_cnt=2; force count 16'hFFFF, one more grant -> stays 16'hFFFF.

Source files
------------

// File: rtl/red_pkg.sv
// Shared definitions for the RED reduction arbiter: FSM encoding, datapath
// width, requester id width and the latched-operand record.
package red_pkg;

  localparam int RED_W = 16;
  localparam int ID_W  = 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  typedef logic [RED_W-1:0] red_word_t;
  typedef logic [ID_W-1:0]  red_id_t;

  typedef struct packed {
    red_id_t   id;
    red_word_t a;
    red_word_t b;
  } red_op_t;

endpackage

// File: rtl/red_16bit.sv
// Combinational RED reduction: A={a,b}, B={c,d}, all signed 8-bit;
// result is the exact (a+b)+(c+d) sign-extended to RED_W bits.
module red_16bit
  import red_pkg::*;
(
  input  logic [RED_W-1:0] i_a,
  input  logic [RED_W-1:0] i_b,
  output logic [RED_W-1:0] o_sum
);

  logic [8:0] w_sum_ab;
  logic [8:0] w_sum_cd;
  logic [9:0] w_sum;

  // One guard bit per stage keeps every partial sum exact.
  assign w_sum_ab = {i_a[15], i_a[15:8]} + {i_a[7], i_a[7:0]};
  assign w_sum_cd = {i_b[15], i_b[15:8]} + {i_b[7], i_b[7:0]};
  assign w_sum    = {w_sum_ab[8], w_sum_ab} + {w_sum_cd[8], w_sum_cd};
  assign o_sum    = {{(RED_W-10){w_sum[9]}}, w_sum};

endmodule

// File: rtl/red_arbiter.sv
// Two-requester round-robin front end for a single red_16bit datapath.
// Define RED_ARB_STATS_EN to add saturating per-requester grant counters.
module red_arbiter
  import red_pkg::*;
#(
  parameter bit RR_RESET_PRI = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_vld,
  input  logic [RED_W-1:0] req0_A,
  input  logic [RED_W-1:0] req0_B,
  output logic             req0_rdy,
  input  logic             req1_vld,
  input  logic [RED_W-1:0] req1_A,
  input  logic [RED_W-1:0] req1_B,
  output logic             req1_rdy,
  output logic             rsp_vld,
  output logic [ID_W-1:0]  rsp_id,
  output logic [RED_W-1:0] rsp_sum,
  input  logic             rsp_rdy
`ifdef RED_ARB_STATS_EN
  ,
  output logic [15:0]      gnt0_cnt,
  output logic [15:0]      gnt1_cnt
`endif
);

  logic [1:0] r_state;
  logic       r_last_grant;
  red_op_t    r_op;
  logic       r_rsp_vld;
  red_id_t    r_rsp_id;
  red_word_t  r_rsp_sum;

  logic       w_idle;
  logic       w_gnt0;
  logic       w_gnt1;
  red_word_t  w_red_sum;

  // Grants are mutually exclusive: under contention r_last_grant picks exactly one.
  assign w_idle = (r_state == ST_IDLE);
  assign w_gnt0 = w_idle & req0_vld & (~req1_vld | r_last_grant);
  assign w_gnt1 = w_idle & req1_vld & (~req0_vld | ~r_last_grant);

  assign req0_rdy = w_gnt0;
  assign req1_rdy = w_gnt1;

  red_16bit u_red (
    .i_a   (r_op.a),
    .i_b   (r_op.b),
    .o_sum (w_red_sum)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= ~RR_RESET_PRI;
      r_op         <= '0;
      r_rsp_vld    <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_sum    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt0 | w_gnt1) begin
            r_state      <= ST_EXEC;
            r_last_grant <= w_gnt1;
            r_op.id      <= w_gnt1;
            r_op.a       <= w_gnt1 ? req1_A : req0_A;
            r_op.b       <= w_gnt1 ? req1_B : req0_B;
          end
        end
        ST_EXEC: begin
          r_rsp_sum <= w_red_sum;
          r_rsp_id  <= r_op.id;
          r_rsp_vld <= 1'b1;
          r_state   <= ST_HOLD;
        end
        ST_HOLD: begin
          if (rsp_rdy) begin
            r_rsp_vld <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_vld = r_rsp_vld;
  assign rsp_id  = r_rsp_id;
  assign rsp_sum = r_rsp_sum;

`ifdef RED_ARB_STATS_EN
  logic [15:0] r_gnt0_cnt;
  logic [15:0] r_gnt1_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gnt0_cnt <= '0;
      r_gnt1_cnt <= '0;
    end else begin
      if (w_gnt0 && (r_gnt0_cnt != 16'hFFFF)) r_gnt0_cnt <= r_gnt0_cnt + 16'd1;
      if (w_gnt1 && (r_gnt1_cnt != 16'hFFFF)) r_gnt1_cnt <= r_gnt1_cnt + 16'd1;
    end
  end

  assign gnt0_cnt = r_gnt0_cnt;
  assign gnt1_cnt = r_gnt1_cnt;
`endif

endmodule

// File: tb/tb_red_arbiter.sv
// Self-checking bench for red_arbiter: directed scenarios plus randomized
// traffic against a transaction-level reference model.
module tb_red_arbiter;

  localparam bit P = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_vld, req1_vld, rsp_rdy;
  logic [15:0] req0_A, req0_B, req1_A, req1_B;
  logic        req0_rdy, req1_rdy, rsp_vld;
  logic [0:0]  rsp_id;
  logic [15:0] rsp_sum;
`ifdef RED_ARB_STATS_EN
  logic [15:0] gnt0_cnt, gnt1_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one outstanding transaction, visible after m_wait edges.
  bit          m_last;
  bit          m_pending;
  int          m_wait;
  bit          m_id;
  logic [15:0] m_sum;
  bit          gnt_log[$];

  always #5 clk = ~clk;

  red_arbiter #(.RR_RESET_PRI(P)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0_vld (req0_vld),
    .req0_A   (req0_A),
    .req0_B   (req0_B),
    .req0_rdy (req0_rdy),
    .req1_vld (req1_vld),
    .req1_A   (req1_A),
    .req1_B   (req1_B),
    .req1_rdy (req1_rdy),
    .rsp_vld  (rsp_vld),
    .rsp_id   (rsp_id),
    .rsp_sum  (rsp_sum),
    .rsp_rdy  (rsp_rdy)
`ifdef RED_ARB_STATS_EN
    ,
    .gnt0_cnt (gnt0_cnt),
    .gnt1_cnt (gnt1_cnt)
`endif
  );

  function automatic logic [15:0] ref_sum(input logic [15:0] a, input logic [15:0] b);
    int s;
    s = int'($signed(a[15:8])) + int'($signed(a[7:0])) +
        int'($signed(b[15:8])) + int'($signed(b[7:0]));
    return s[15:0];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req0_vld = 1'b0; req1_vld = 1'b0; rsp_rdy = 1'b0;
    req0_A = '0; req0_B = '0; req1_A = '0; req1_B = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_last = ~P; m_pending = 1'b0; m_wait = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if ({rsp_vld, rsp_id, rsp_sum} !== 18'd0) begin
      n_errors++;
      $display("FAIL reset_rsp: got vld=%b id=%b sum=%h want 0/0/0000", rsp_vld, rsp_id, rsp_sum);
    end
    n_checks++;
    if ({req0_rdy, req1_rdy} !== 2'b00) begin
      n_errors++;
      $display("FAIL reset_rdy: got %b%b want 00", req0_rdy, req1_rdy);
    end
`ifdef RED_ARB_STATS_EN
    n_checks++;
    if ({gnt0_cnt, gnt1_cnt} !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_cnt: got %h/%h want 0000/0000", gnt0_cnt, gnt1_cnt);
    end
`endif
  endtask

  task automatic test_single(input bit id, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] exp_sum, input string name);
    @(negedge clk);
    if (id) begin req1_vld = 1'b1; req1_A = a; req1_B = b; end
    else    begin req0_vld = 1'b1; req0_A = a; req0_B = b; end
    #1;
    n_checks++;
    if ({req1_rdy, req0_rdy} !== (id ? 2'b10 : 2'b01)) begin
      n_errors++;
      $display("FAIL %s_accept: got rdy1/0=%b%b want id %0d only", name, req1_rdy, req0_rdy, id);
    end
    @(negedge clk);
    req0_vld = 1'b0; req1_vld = 1'b0;
    req0_A = $urandom; req0_B = $urandom; req1_A = $urandom; req1_B = $urandom;
    #1;
    n_checks++;
    if (rsp_vld !== 1'b0) begin
      n_errors++;
      $display("FAIL %s_early: got rsp_vld=%b want 0 at t+1", name, rsp_vld);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (rsp_vld !== 1'b1 || rsp_id !== id || rsp_sum !== exp_sum) begin
      n_errors++;
      $display("FAIL %s_rsp: got vld=%b id=%b sum=%h want 1/%0d/%h", name, rsp_vld, rsp_id, rsp_sum, id, exp_sum);
    end
    $display("txn %s: id=%0d A=%h B=%h sum=%h", name, id, a, b, rsp_sum);
    rsp_rdy = 1'b1;
    @(negedge clk);
    rsp_rdy = 1'b0;
    #1;
    n_checks++;
    if (rsp_vld !== 1'b0) begin
      n_errors++;
      $display("FAIL %s_consume: got rsp_vld=%b want 0", name, rsp_vld);
    end
    m_last = id;
  endtask

  task automatic test_basic();
    test_single(1'b0, 16'h7F7F, 16'h0101, 16'h0100, "basic");
  endtask

  task automatic test_negative();
    test_single(1'b1, 16'h8080, 16'hFFFF, 16'hFEFE, "negative");
  endtask

  // Cycle loop driving random traffic and comparing against the model.
  task automatic run_traffic(input int n, input int pct0, input int pct1, input int pct_rdy);
    bit e0, e1, exp_vld;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req0_vld = ($urandom_range(99) < pct0);
      req1_vld = ($urandom_range(99) < pct1);
      req0_A = $urandom; req0_B = $urandom; req1_A = $urandom; req1_B = $urandom;
      rsp_rdy = ($urandom_range(99) < pct_rdy);
      #1;
      e0 = 1'b0; e1 = 1'b0;
      if (!m_pending) begin
        if (req0_vld && req1_vld) begin e0 = m_last; e1 = ~m_last; end
        else begin e0 = req0_vld; e1 = req1_vld; end
      end
      n_checks++;
      if (req0_rdy !== e0 || req1_rdy !== e1) begin
        n_errors++;
        $display("FAIL traffic_rdy cyc %0d: got %b%b want %b%b", i, req0_rdy, req1_rdy, e0, e1);
      end
      exp_vld = m_pending && (m_wait == 0);
      n_checks++;
      if (rsp_vld !== exp_vld || (exp_vld && (rsp_id !== m_id || rsp_sum !== m_sum))) begin
        n_errors++;
        $display("FAIL traffic_rsp cyc %0d: got vld=%b id=%b sum=%h want %b/%0d/%h",
                 i, rsp_vld, rsp_id, rsp_sum, exp_vld, m_id, m_sum);
      end
      if (m_pending) begin
        if (m_wait > 0) m_wait--;
        else if (rsp_rdy) m_pending = 1'b0;
      end else if (e0 || e1) begin
        m_pending = 1'b1;
        m_wait    = 1;
        m_id      = e1;
        m_sum     = e1 ? ref_sum(req1_A, req1_B) : ref_sum(req0_A, req0_B);
        m_last    = e1;
        gnt_log.push_back(e1);
        $display("txn traffic: cyc %0d id=%0d sum=%h", i, e1, m_sum);
      end
    end
    @(negedge clk);
    req0_vld = 1'b0; req1_vld = 1'b0; rsp_rdy = 1'b0;
  endtask

  task automatic test_contention();
    bit want;
    do_reset();
    gnt_log.delete();
    run_traffic(12, 100, 100, 100);
    n_checks++;
    if (gnt_log.size() != 4) begin
      n_errors++;
      $display("FAIL contention_count: got %0d grants want 4", gnt_log.size());
    end
    for (int i = 0; i < gnt_log.size() && i < 4; i++) begin
      want = P ^ i[0];
      n_checks++;
      if (gnt_log[i] !== want) begin
        n_errors++;
        $display("FAIL contention_order[%0d]: got %0d want %0d", i, gnt_log[i], want);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp;
    do_reset();
    @(negedge clk);
    req0_vld = 1'b1; req0_A = $urandom; req0_B = $urandom;
    exp = ref_sum(req0_A, req0_B);
    #1;
    n_checks++;
    if (req0_rdy !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_accept: got req0_rdy=%b want 1", req0_rdy);
    end
    @(negedge clk);
    req1_vld = 1'b1;
    #1;
    n_checks++;
    if ({req0_rdy, req1_rdy} !== 2'b00) begin
      n_errors++;
      $display("FAIL bp_exec_rdy: got %b%b want 00", req0_rdy, req1_rdy);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (rsp_vld !== 1'b1 || rsp_id !== 1'b0 || rsp_sum !== exp || req0_rdy !== 1'b0 || req1_rdy !== 1'b0) begin
        n_errors++;
        $display("FAIL bp_hold[%0d]: got vld=%b id=%b sum=%h rdy=%b%b want 1/0/%h/00",
                 i, rsp_vld, rsp_id, rsp_sum, req0_rdy, req1_rdy, exp);
      end
    end
    $display("txn backpressure: id=0 sum=%h held 5 cycles", rsp_sum);
    rsp_rdy = 1'b1;
    @(negedge clk);
    rsp_rdy = 1'b0;
    #1;
    n_checks++;
    if (rsp_vld !== 1'b0 || req0_rdy !== 1'b0 || req1_rdy !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_release: got vld=%b rdy=%b%b want 0/01", rsp_vld, req0_rdy, req1_rdy);
    end
    req0_vld = 1'b0; req1_vld = 1'b0;
  endtask

  task automatic test_reset_mid_exec();
    bit want0;
    do_reset();
    @(negedge clk);
    req0_vld = 1'b1; req0_A = 16'h1234; req0_B = 16'h5678;
    #1;
    n_checks++;
    if (req0_rdy !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_exec_accept: got req0_rdy=%b want 1", req0_rdy);
    end
    @(negedge clk);
    req0_vld = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (rsp_vld !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_exec_vld: got rsp_vld=%b want 0", rsp_vld);
    end
    @(negedge clk);
    req0_vld = 1'b1; req1_vld = 1'b1;
    #1;
    want0 = (P == 1'b0);
    n_checks++;
    if ({rsp_vld, rsp_id, rsp_sum} !== 18'd0) begin
      n_errors++;
      $display("FAIL rst_exec_outputs: got vld=%b id=%b sum=%h want 0/0/0000", rsp_vld, rsp_id, rsp_sum);
    end
    n_checks++;
    if (req0_rdy !== want0 || req1_rdy !== ~want0) begin
      n_errors++;
      $display("FAIL rst_exec_priority: got rdy=%b%b want %b%b", req0_rdy, req1_rdy, want0, ~want0);
    end
    $display("txn reset_mid_exec: transaction discarded");
    req0_vld = 1'b0; req1_vld = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    run_traffic(600, 55, 55, 60);
  endtask

`ifdef RED_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rsp_rdy = 1'b1;
      if (i >= 3) req1_vld = 1'b1; else req0_vld = 1'b1;
      @(negedge clk);
      req0_vld = 1'b0; req1_vld = 1'b0;
      @(negedge clk);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (gnt0_cnt !== 16'd3 || gnt1_cnt !== 16'd2) begin
      n_errors++;
      $display("FAIL stats_count: got %0d/%0d want 3/2", gnt0_cnt, gnt1_cnt);
    end
    force dut.r_gnt0_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.r_gnt0_cnt;
    req0_vld = 1'b1;
    @(negedge clk);
    req0_vld = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (gnt0_cnt !== 16'hFFFF || gnt1_cnt !== 16'd2) begin
      n_errors++;
      $display("FAIL stats_saturate: got %h/%0d want FFFF/2", gnt0_cnt, gnt1_cnt);
    end
    rsp_rdy = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_contention();
    test_backpressure();
    test_reset_mid_exec();
    test_random();
`ifdef RED_ARB_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
